// File: rtl/piso_tx_if.sv
// piso_tx_if -- load handshake and serial-output bundle for piso_tx.
//   pi          parallel word offered by the sender
//   load_valid  pi holds a word to transmit
//   load_ready  transmitter accepts pi this cycle
//   so          serial data bit (0 when so_valid is low)
//   so_valid    so carries a frame bit this cycle
//   done        one-cycle pulse on the last bit of a word
//   busy        a word is being shifted out
// master: sender/observer side; slave: the transmitter.
interface piso_tx_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] pi;
    logic             load_valid;
    logic             load_ready;
    logic             so;
    logic             so_valid;
    logic             done;
    logic             busy;

    modport master (
        output pi, load_valid,
        input  load_ready, so, so_valid, done, busy
    );

    modport slave (
        input  pi, load_valid,
        output load_ready, so, so_valid, done, busy
    );
endinterface

// File: rtl/piso_tx.sv
// piso_tx -- parallel-in serial-out transmitter.
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   piso_tx_if.slave: pi/load_valid/load_ready load handshake,
//         registered so/so_valid/done/busy serial outputs
// Parameters: WIDTH bits per word (>= 2); MSB_FIRST selects bit order
// (0 = LSB first). A word accepted at edge k shows bit i on so in cycle
// k+1+i. A new word may be accepted on the last-bit cycle, giving
// gap-free back-to-back frames.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic     clk,
    input logic     rst,
    piso_tx_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             so_q, so_d;
    logic             so_valid_q, so_valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ready;
    logic             accept;

    // Ready in IDLE, or on the last-bit cycle so the next word follows
    // without a gap; held low throughout reset.
    assign ready  = rst && ((state == IDLE) || ((state == SHIFT) && (cnt == LAST)));
    assign accept = bus.load_valid && ready;

    assign bus.load_ready = ready;
    assign bus.so         = so_q;
    assign bus.so_valid   = so_valid_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            cnt        <= cnt_d;
            so_q       <= so_d;
            so_valid_q <= so_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // so is registered, so the first bit is taken straight from pi at the
    // load edge; shreg keeps the word and later bits come from shreg
    // shifted one position ahead of the bit currently on so.
    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        cnt_d      = cnt;
        so_d       = 1'b0;
        so_valid_d = 1'b0;
        done_d     = 1'b0;
        busy_d     = 1'b0;

        if (accept) begin
            state_d    = SHIFT;
            shreg_d    = bus.pi;
            cnt_d      = '0;
            so_d       = MSB_FIRST ? bus.pi[WIDTH-1] : bus.pi[0];
            so_valid_d = 1'b1;
            busy_d     = 1'b1;
        end else if (state == SHIFT) begin
            if (cnt == LAST) begin
                state_d = IDLE;
            end else begin
                cnt_d      = cnt + CW'(1);
                so_valid_d = 1'b1;
                busy_d     = 1'b1;
                done_d     = (cnt_d == LAST);
                if (MSB_FIRST) begin
                    shreg_d = shreg << 1;
                    so_d    = shreg[WIDTH-2];
                end else begin
                    shreg_d = shreg >> 1;
                    so_d    = shreg[1];
                end
            end
        end
    end
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4, number of bits per serialized word (WIDTH >= 2).
REQ-002 Parameter MSB_FIRST, default 0, bit order: 0 = LSB first, 1 = MSB first.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (rst=0 at a rising clk edge resets the block).
REQ-005 pi  input  WIDTH  parallel word to transmit.
REQ-006 load_valid  input  1  pi holds a word to transmit.
REQ-007 load_ready  output  1  block accepts pi this cycle.
REQ-008 so  output  1  serial data bit.
REQ-009 so_valid  output  1  so carries a frame bit this cycle.
REQ-010 done  output  1  one-cycle pulse marking the last bit of a word.
REQ-011 busy  output  1  a word is being shifted out.

Function
REQ-012 Two-state FSM: IDLE and SHIFT.
REQ-013 Load handshake: a word is accepted at a rising edge where load_valid=1 and load_ready=1; pi is captured into an internal WIDTH-bit shift register, and the bit counter is cleared to 0.
REQ-014 load_ready is combinational: 1 in IDLE; in SHIFT, 1 only when the bit counter = WIDTH-1 (last-bit cycle); 0 otherwise.
REQ-015 IDLE -> SHIFT on an accepted load; SHIFT -> IDLE after the last bit when no new load is accepted in that cycle.
REQ-016 SHIFT -> SHIFT with a new word when a load is accepted on the last-bit cycle; no idle gap between words.
REQ-017 so, so_valid, done and busy are registered outputs.
REQ-018 Latency: load accepted at edge k -> first bit on so in cycle k+1; bit i on so in cycle k+1+i for i = 0..WIDTH-1.
REQ-019 With MSB_FIRST=0, bit i on so is pi[i]; with MSB_FIRST=1, bit i on so is pi[WIDTH-1-i].
REQ-020 so_valid=1 and busy=1 in every cycle that carries a frame bit; both 0 otherwise.
REQ-021 done=1 only in the cycle carrying bit WIDTH-1; it is asserted once per word, including on back-to-back words.
REQ-022 While so_valid=0, so is held at 0.
REQ-023 When load_ready=0, load_valid and pi are ignored; no word is captured or lost, and the sender holds load_valid.
REQ-024 The bit counter is ceil(log2(WIDTH)) bits wide and never exceeds WIDTH-1.
REQ-025 The output stream is compatible with a WIDTH-bit shift-in receiver that shifts new bits in at the MSB: after WIDTH so_valid cycles, that receiver holds pi (MSB_FIRST=0).

Reset
REQ-026 rst=0 at an edge forces IDLE, the shift register to 0, the bit counter to 0, so=0, so_valid=0, done=0 and busy=0.
REQ-027 While rst=0, load_ready=0 and no load is accepted.
REQ-028 A reset during SHIFT aborts the word; no remaining bits and no done pulse appear after the reset.
REQ-029 The first accepted load after rst returns to 1 behaves per REQ-018.

Verification
REQ-030 Single word: WIDTH=4, MSB_FIRST=0, pi=4'b1011, load_valid pulsed in IDLE -> so = 1,1,0,1 in the next 4 cycles, so_valid=1 for exactly 4 cycles, done=1 on the 4th only.
REQ-031 Back-to-back: pi=4'hA then 4'h5, load_valid held high -> 8 consecutive so_valid cycles with so = 0,1,0,1,1,0,1,0, and done on cycles 4 and 8.
REQ-032 Busy ignore: 4'h3 accepted, then pi=4'hF with load_valid=1 during bits 0-2 -> load_ready=0, stream stays 1,1,0,0, and 4'hF is accepted on the last-bit cycle.
REQ-033 Reset mid-word: 4'b1111 accepted, rst=0 at the edge ending bit 1 -> next cycle so=0, so_valid=0, busy=0, and no done pulse.
REQ-034 MSB_FIRST=1, pi=4'b1000 -> so = 1,0,0,0.
REQ-035 Loopback into a 4-bit shift-in receiver over 16 random words -> the receiver's parallel output equals each pi after its done cycle.
